iq_upmix_tx: RTL and testbench

- Transmit-side quadrature modulator, the counterpart of the receive IQ down-mixer.
- Accepts baseband I/Q samples at the low rate (clk rate / FACTOR) over a valid/ready handshake.
- Interpolates each rail by FACTOR with a 3-stage CIC interpolator, then mixes onto a numerically controlled carrier.
- Emits one real IF sample per clock: I·cos − Q·sin.

---
 rtl/iq_upmix_tx.sv | 205 ++++++++++++++++++++
 tb/tb_iq_upmix_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/iq_upmix_tx.sv
// Transmit quadrature modulator: 3-stage CIC interpolation of baseband I/Q,
// then mixing onto an NCO carrier to produce one real IF sample per clock.
module iq_upmix_tx #(
   parameter int LO_WIDTH     = 12,
   parameter int PHASE_WIDTH  = 32,
   parameter int LUT_ADDR     = 10,
   parameter int FACTOR       = 400,
   parameter int INPUT_WIDTH  = 12,
   parameter int OUTPUT_WIDTH = 12,
   parameter int GAIN_SHIFT   = 18
) (
   input  logic                           clk_in,
   input  logic                           RST,
   input  logic [PHASE_WIDTH-1:0]         Fre_word,
   input  logic signed [INPUT_WIDTH-1:0]  I_IN,
   input  logic signed [INPUT_WIDTH-1:0]  Q_IN,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic signed [OUTPUT_WIDTH-1:0] wave_out,
   output logic                           out_valid,
   output logic                           underrun
);

   localparam int CNT_W  = (FACTOR > 1) ? $clog2(FACTOR) : 1;
   localparam int CIC_W  = INPUT_WIDTH + $clog2(FACTOR * FACTOR);
   localparam int PROD_W = INPUT_WIDTH + LO_WIDTH;
   localparam int DIFF_W = PROD_W + 1;
   localparam int OUT_SH = PROD_W - OUTPUT_WIDTH - 1;
   localparam int ROM_N  = 2 ** LUT_ADDR;
   localparam int IDX_W  = LUT_ADDR + 2;

   localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(FACTOR - 1);
   localparam logic signed [CIC_W-1:0]   RAIL_MAX = CIC_W'(2 ** (INPUT_WIDTH - 1) - 1);
   localparam logic signed [CIC_W-1:0]   RAIL_MIN = CIC_W'(-(2 ** (INPUT_WIDTH - 1)));
   localparam logic signed [DIFF_W-1:0]  OUT_MAX  = DIFF_W'(2 ** (OUTPUT_WIDTH - 1) - 1);
   localparam logic signed [DIFF_W-1:0]  OUT_MIN  = -OUT_MAX;
   localparam logic signed [LO_WIDTH-1:0] LO_FULL = LO_WIDTH'(2 ** (LO_WIDTH - 1) - 1);
   localparam logic [IDX_W-1:0]          QUARTER  = {2'b01, {LUT_ADDR{1'b0}}};

   // Elaboration-time sine table; Taylor series keeps it free of math builtins.
   function automatic int rom_val(input int k);
      real x, term, s;
      x    = 3.14159265358979323846 / 2.0 * real'(k) / real'(ROM_N);
      term = x;
      s    = x;
      for (int unsigned n = 1; n < 12; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         s    = s + term;
      end
      return $rtoi(s * real'(2 ** (LO_WIDTH - 1) - 1) + 0.5);
   endfunction

   logic signed [LO_WIDTH-1:0] rom [ROM_N];

   for (genvar k = 0; k < ROM_N; k++) begin : g_rom
      localparam int VAL = rom_val(k);
      assign rom[k] = LO_WIDTH'(VAL);
   end

   logic [CNT_W-1:0]              slot_cnt;
   logic                          slot_zero;
   logic                          comb_stb;
   logic                          underrun_r;
   logic [3:0]                    vld_pipe;
   logic signed [INPUT_WIDTH-1:0] hold [2];

   assign slot_zero = (slot_cnt == '0);
   assign in_ready  = slot_zero & ~RST;
   assign underrun  = underrun_r;
   assign out_valid = vld_pipe[3];

   always_ff @(posedge clk_in or posedge RST) begin
      if (RST) begin
         slot_cnt   <= '0;
         comb_stb   <= 1'b0;
         underrun_r <= 1'b0;
         vld_pipe   <= '0;
         hold[0]    <= '0;
         hold[1]    <= '0;
      end else begin
         slot_cnt <= (slot_cnt == CNT_LAST) ? '0 : slot_cnt + CNT_W'(1);
         comb_stb <= slot_zero;
         if (slot_zero) begin
            if (in_valid) begin
               hold[0] <= I_IN;
               hold[1] <= Q_IN;
            end else begin
               underrun_r <= 1'b1;
            end
         end
         vld_pipe <= {vld_pipe[2:0], vld_pipe[0] | (slot_zero & in_valid)};
      end
   end

   // CIC per rail: combs run at the slot rate off the held sample, integrators every clock.
   logic signed [CIC_W-1:0]       comb_dly [2][3];
   logic signed [CIC_W-1:0]       comb_c   [2][3];
   logic signed [CIC_W-1:0]       stuff    [2];
   logic signed [CIC_W-1:0]       integ    [2][3];
   logic signed [CIC_W-1:0]       rail_sh  [2];
   logic signed [INPUT_WIDTH-1:0] rail     [2];

   always_comb begin
      for (int unsigned r = 0; r < 2; r++) begin
         comb_c[r][0] = CIC_W'(hold[r]) - comb_dly[r][0];
         comb_c[r][1] = comb_c[r][0] - comb_dly[r][1];
         comb_c[r][2] = comb_c[r][1] - comb_dly[r][2];
         stuff[r]     = comb_stb ? comb_c[r][2] : '0;
         rail_sh[r]   = integ[r][2] >>> GAIN_SHIFT;
         if (rail_sh[r] > RAIL_MAX)
            rail[r] = RAIL_MAX[INPUT_WIDTH-1:0];
         else if (rail_sh[r] < RAIL_MIN)
            rail[r] = RAIL_MIN[INPUT_WIDTH-1:0];
         else
            rail[r] = rail_sh[r][INPUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_in or posedge RST) begin
      if (RST) begin
         for (int unsigned r = 0; r < 2; r++) begin
            for (int unsigned s = 0; s < 3; s++) begin
               comb_dly[r][s] <= '0;
               integ[r][s]    <= '0;
            end
         end
      end else begin
         for (int unsigned r = 0; r < 2; r++) begin
            if (comb_stb) begin
               comb_dly[r][0] <= CIC_W'(hold[r]);
               comb_dly[r][1] <= comb_c[r][0];
               comb_dly[r][2] <= comb_c[r][1];
            end
            integ[r][0] <= integ[r][0] + stuff[r];
            integ[r][1] <= integ[r][1] + integ[r][0];
            integ[r][2] <= integ[r][2] + integ[r][1];
         end
      end
   end

   // NCO with quarter-wave folding; index 0 is sin, index 1 is cos.
   logic [PHASE_WIDTH-1:0]     phase;
   logic [IDX_W-1:0]           lo_idx [2];
   logic [1:0]                 quad;
   logic [LUT_ADDR-1:0]        addr;
   logic signed [LO_WIDTH-1:0] mag;
   logic signed [LO_WIDTH-1:0] lo [2];

   always_comb begin
      quad      = '0;
      addr      = '0;
      mag       = '0;
      lo_idx[0] = phase[PHASE_WIDTH-1 -: IDX_W];
      lo_idx[1] = lo_idx[0] + QUARTER;
      for (int unsigned j = 0; j < 2; j++) begin
         quad = lo_idx[j][IDX_W-1 -: 2];
         addr = lo_idx[j][LUT_ADDR-1:0];
         if (!quad[0])
            mag = rom[addr];
         else if (addr == '0)
            mag = LO_FULL;
         else
            mag = rom[~addr + LUT_ADDR'(1)];
         lo[j] = quad[1] ? -mag : mag;
      end
   end

   logic signed [LO_WIDTH-1:0]    lo_r   [2];
   logic signed [INPUT_WIDTH-1:0] rail_r [2];
   logic signed [PROD_W-1:0]      prod   [2];
   logic signed [DIFF_W-1:0]      diff;
   logic signed [DIFF_W-1:0]      diff_sh;

   always_ff @(posedge clk_in or posedge RST) begin
      if (RST) begin
         phase <= '0;
         for (int unsigned j = 0; j < 2; j++) begin
            lo_r[j]   <= '0;
            rail_r[j] <= '0;
            prod[j]   <= '0;
         end
         diff <= '0;
      end else begin
         phase <= phase + Fre_word;
         for (int unsigned j = 0; j < 2; j++) begin
            lo_r[j]   <= lo[j];
            rail_r[j] <= rail[j];
         end
         prod[0] <= PROD_W'(rail_r[0]) * PROD_W'(lo_r[1]);
         prod[1] <= PROD_W'(rail_r[1]) * PROD_W'(lo_r[0]);
         diff    <= DIFF_W'(prod[0]) - DIFF_W'(prod[1]);
      end
   end

   always_comb begin
      diff_sh = diff >>> OUT_SH;
      if (diff_sh > OUT_MAX)
         wave_out = OUT_MAX[OUTPUT_WIDTH-1:0];
      else if (diff_sh < OUT_MIN)
         wave_out = OUT_MIN[OUTPUT_WIDTH-1:0];
      else
         wave_out = diff_sh[OUTPUT_WIDTH-1:0];
   end

endmodule

// File: tb/tb_iq_upmix_tx.sv
// Scoreboard bench for iq_upmix_tx: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_iq_upmix_tx;

   localparam int SIG_WAVE = 0;
   localparam int SIG_RDY  = 1;
   localparam int SIG_OVLD = 2;
   localparam int SIG_UND  = 3;

   typedef struct {
      int    cyc;   // edges since reset release; -1 means next negedge
      int    sig;
      int    exp;
      int    tol;
      string name;
   } exp_t;

   logic               clk_in   = 1'b0;
   logic               RST      = 1'b1;
   logic [31:0]        Fre_word = '0;
   logic signed [11:0] I_IN     = '0;
   logic signed [11:0] Q_IN     = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [11:0] wave_out;
   logic               out_valid;
   logic               underrun;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   n      = 0;

   iq_upmix_tx #(
      .LO_WIDTH(12), .PHASE_WIDTH(32), .LUT_ADDR(10), .FACTOR(400),
      .INPUT_WIDTH(12), .OUTPUT_WIDTH(12), .GAIN_SHIFT(18)
   ) dut (
      .clk_in(clk_in), .RST(RST), .Fre_word(Fre_word), .I_IN(I_IN), .Q_IN(Q_IN),
      .in_valid(in_valid), .in_ready(in_ready), .wave_out(wave_out),
      .out_valid(out_valid), .underrun(underrun)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      if (RST) n <= 0;
      else     n <= n + 1;
   end

   always @(negedge clk_in) begin : monitor
      exp_t e;
      int   act;
      int   d;
      while (sb.size() > 0 && (sb[0].cyc < 0 || (!RST && n >= sb[0].cyc))) begin
         e = sb.pop_front();
         case (e.sig)
            SIG_WAVE: act = int'(wave_out);
            SIG_RDY:  act = int'(in_ready);
            SIG_OVLD: act = int'(out_valid);
            default:  act = int'(underrun);
         endcase
         d = act - e.exp;
         if (d < 0) d = -d;
         checks++;
         if (d > e.tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", e.name, act, e.exp, e.tol, n);
         end
      end
   end

   task automatic expect_at(input int cyc, input int sig, input int ev, input int tol, input string name);
      exp_t e;
      e.cyc = cyc; e.sig = sig; e.exp = ev; e.tol = tol; e.name = name;
      sb.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int ev);
      checks++;
      if (act != ev) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, ev);
      end
   endtask

   task automatic start_run(input logic [31:0] fw, input int i, input int q);
      @(posedge clk_in);
      #2;
      RST      = 1'b1;
      Fre_word = fw;
      I_IN     = 12'(i);
      Q_IN     = 12'(q);
      in_valid = 1'b1;
      repeat (2) @(posedge clk_in);
      #2;
      RST = 1'b0;
      expect_at(0, SIG_RDY,  1, 0, "rdy_first_cycle");
      expect_at(0, SIG_OVLD, 0, 0, "ovld_after_rst");
      expect_at(0, SIG_UND,  0, 0, "und_after_rst");
      expect_at(0, SIG_WAVE, 0, 0, "wave_after_rst");
      expect_at(1, SIG_RDY,  0, 0, "rdy_one_cycle");
      expect_at(3, SIG_OVLD, 0, 0, "ovld_early");
      expect_at(4, SIG_OVLD, 1, 0, "ovld_latency");
   endtask

   task automatic wait_n(input int target);
      while (n < target) @(negedge clk_in);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, pending=%0d expected 0", sb.size());
      $fatal(1);
   end

   initial begin : stimulus
      int rdy_cnt;
      int acc_cnt;
      int pat4i[4];
      int pat4q[4];
      int pat8[8];
      int guard;
      pat4i = '{609, 0, -610, 0};
      pat4q = '{0, -610, 0, 609};
      pat8  = '{1248, 1765, 1249, 0, -1249, -1766, -1250, -1};

      // DC carrier, handshake cadence, underrun, mid-stream reset
      start_run(32'd0, 1000, 0);
      expect_at(399, SIG_RDY, 0, 0, "rdy_399");
      expect_at(400, SIG_RDY, 1, 0, "rdy_400");
      expect_at(401, SIG_RDY, 0, 0, "rdy_401");
      expect_at(800, SIG_RDY, 1, 0, "rdy_800");
      for (int k = 1300; k < 1304; k++) expect_at(k, SIG_WAVE, 609, 1, "wave_dc");
      expect_at(1600, SIG_RDY,  1, 0, "rdy_1600");
      expect_at(1600, SIG_UND,  0, 0, "und_before_drop");
      expect_at(1601, SIG_UND,  1, 0, "und_set");
      expect_at(1601, SIG_RDY,  0, 0, "rdy_1601");
      expect_at(1700, SIG_WAVE, 609, 1, "wave_held");
      expect_at(2400, SIG_UND,  1, 0, "und_sticky");
      expect_at(2500, SIG_WAVE, 609, 1, "wave_held_late");

      rdy_cnt = 0;
      acc_cnt = 0;
      repeat (1200) begin
         @(negedge clk_in);
         if (in_ready) rdy_cnt++;
         if (in_ready && in_valid) acc_cnt++;
      end
      check("ready_pulses_1200", rdy_cnt, 3);
      check("accepts_1200", acc_cnt, 3);

      wait_n(1600);
      in_valid = 1'b0;
      @(negedge clk_in);
      in_valid = 1'b1;

      wait_n(2600);
      @(posedge clk_in);
      #2;
      RST = 1'b1;
      expect_at(-1, SIG_RDY,  0, 0, "rst_rdy");
      expect_at(-1, SIG_OVLD, 0, 0, "rst_ovld");
      expect_at(-1, SIG_WAVE, 0, 0, "rst_wave");
      expect_at(-1, SIG_UND,  0, 0, "rst_und");

      // carrier at fs/4, I rail
      start_run(32'h4000_0000, 1000, 0);
      for (int k = 1300; k < 1308; k++) expect_at(k, SIG_WAVE, pat4i[(k - 3) % 4], 1, "fs4_i");
      wait_n(1310);

      // carrier at fs/4, Q rail: one-cycle shift of the I pattern
      start_run(32'h4000_0000, 0, 1000);
      for (int k = 1300; k < 1308; k++) expect_at(k, SIG_WAVE, pat4q[(k - 3) % 4], 1, "fs4_q");
      wait_n(1310);

      // full-scale inputs at fs/8: range-bounded throughout, exact at steady state
      start_run(32'h2000_0000, 2047, -2048);
      for (int k = 10; k < 1300; k += 10) expect_at(k, SIG_WAVE, 0, 2047, "fs8_range");
      for (int k = 1300; k < 1316; k++) expect_at(k, SIG_WAVE, pat8[(k - 3) % 8], 1, "fs8_full");
      wait_n(1320);

      guard = 0;
      while (sb.size() > 0 && guard < 5000) begin
         @(negedge clk_in);
         guard++;
      end
      check("sb_drain", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
